pwm_peripheral: RTL

Sixteen-channel output stage that sits directly downstream of the SPI register block and consumes its five configuration bytes. It generates one shared 8-bit PWM waveform from a prescaled free-running counter. Each of 16 output pins is driven low, driven high, or driven with the PWM waveform, according to the per-bit enable and PWM-select registers. Duty-cycle updates are double-buffered so that every PWM period is glitch-free.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_timebase.sv | 37 +++
 rtl/pwm_peripheral.sv | 72 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, pin-mode type and PWM level helper
package pwm_pkg;

  localparam int PWM_CNT_W       = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_FULL = 8'hFF;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int NUM_PINS        = 16;
  localparam int PRESC_W         = 16;

  typedef enum logic [1:0] {
    PIN_LOW  = 2'd0,
    PIN_HIGH = 2'd1,
    PIN_PWM  = 2'd2
  } pin_mode_e;

  function automatic pin_mode_e pin_mode(input logic en, input logic sel);
    if (!en)      return PIN_LOW;
    else if (sel) return PIN_PWM;
    else          return PIN_HIGH;
  endfunction

  // Full scale is forced high so 0xFF has no 1/256 low sliver.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler and 8-bit PWM counter with tick/wrap strobes
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 tick,
  output logic                 wrap
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    wrap    = tick && (cnt_q == PWM_FULL);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    cnt_d   = tick ? cnt_q + PWM_CNT_W'(1) : cnt_q;
    pwm_cnt = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin output stage with shared double-buffered PWM
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_PINS-1:0]  pwm_out,
  output logic                 period_start
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic                 tick;
  logic                 wrap;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .tick    (tick),
    .wrap    (wrap)
  );

  logic [PWM_CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [NUM_PINS-1:0]  pwm_out_q, pwm_out_d;
  logic                 period_start_q, period_start_d;
  logic [PWM_CNT_W-1:0] cnt_next;
  logic                 pwm_sig_next;
  logic [NUM_PINS-1:0]  en;
  logic [NUM_PINS-1:0]  sel;

  // The level is taken from next-state counter and shadow so a pin's rising
  // edge lands on the same clk edge as period_start.
  always_comb begin
    en             = {en_reg_out_15_8, en_reg_out_7_0};
    sel            = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    duty_sh_d      = wrap ? pwm_duty_cycle : duty_sh_q;
    cnt_next       = tick ? pwm_cnt + PWM_CNT_W'(1) : pwm_cnt;
    pwm_sig_next   = pwm_level(cnt_next, duty_sh_d);
    period_start_d = wrap;
    pwm_out_d      = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      case (pin_mode(en[i], sel[i]))
        PIN_HIGH: pwm_out_d[i] = 1'b1;
        PIN_PWM:  pwm_out_d[i] = pwm_sig_next;
        default:  pwm_out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q      <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_sh_q      <= duty_sh_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule
